lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters: none; widths are fixed by the 32-bit core and the 30-bit word-addressed memory port.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  core presents a load/store request.
REQ-005 req_ready  out  1  lsu accepts; transfer when req_valid && req_ready at a rising edge.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-justified.
REQ-009 req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 resp_valid  out  1  one-cycle pulse completing the request.
REQ-012 resp_rdata  out  32  load result; 0 for stores and errors.
REQ-013 resp_misaligned  out  1  qualified by resp_valid; request rejected without a memory access.
REQ-014 mem_addr  out  30  word address = req_addr[31:2].
REQ-015 mem_din  out  32  write word.
REQ-016 mem_re  out  1  read strobe; memory returns mem_dout on the following cycle.
REQ-017 mem_we  out  1  write strobe, single cycle.
REQ-018 mem_dout  in  32  registered read data from memory.

Function
REQ-019 FSM states: IDLE, RD_ISSUE, RD_WAIT, WR, RESP; req_ready = (state == IDLE) && !rst.
REQ-020 Request fields are captured at acceptance; later input changes have no effect on that request.
REQ-021 Misaligned = size 3, half with addr[0]=1, or word with addr[1:0]!=0; IDLE->RESP, resp_misaligned=1, mem_re and mem_we never asserted.
REQ-022 Timing, with N = accept cycle: load: mem_re N+1, resp_valid N+3; word store: mem_we N+1, resp_valid N+2; misaligned: resp_valid N+1.
REQ-023 Sub-word store (read-modify-write, memory has no byte enables): mem_re N+1, merge in N+2, mem_we N+3 with merged mem_din, resp_valid N+4.
REQ-024 Little-endian lanes: byte lane = addr[1:0], half lane = addr[1]; loads extract the lane and extend per req_unsigned.
REQ-025 Merge replaces only the addressed lane(s) with req_wdata low bits; other lanes keep mem_dout.
REQ-026 mem_re and mem_we are never high in the same cycle; mem_addr is stable from RD_ISSUE through WR.
REQ-027 Outside strobe cycles, mem_re=0 and mem_we=0; mem_din is don't-care but registered.
REQ-028 RESP always returns to IDLE, so the next accept is at the earliest the cycle after resp_valid.
REQ-029 req_valid while not IDLE is ignored; no queuing.

Reset
REQ-030 On rst: state IDLE; resp_valid, resp_misaligned, resp_rdata, mem_re, mem_we, mem_din, mem_addr all 0, asynchronously.
REQ-031 Reset mid-operation abandons the request: no resp_valid, and no pending mem_we is issued.
REQ-032 req_ready is 0 while rst is high and 1 in the first cycle after release.

Structure
REQ-033 Size encodings (SIZE_B/H/W) and the FSM state enum live in the shared core package, and the core decoder uses the same encodings.
REQ-034 One combinational sub-module, lsu_lane, performs load extraction/extension and store merge; the FSM and registers stay in lsu.

Verification (memory model preloaded: word 4 = 0x80817F02)
REQ-035 Signed byte load at 0x13 -> mem_re N+1 with mem_addr 4; resp_valid N+3, resp_rdata 0xFFFFFF80.
REQ-036 Unsigned half load at 0x12 -> resp_rdata 0x00008081, resp_misaligned 0.
REQ-037 Byte store 0xAB at 0x11 -> mem_re N+1, mem_we N+3 with mem_din 0x8081AB02, resp_valid N+4; a following word load at 0x10 returns 0x8081AB02.
REQ-038 Word store 0xDEADBEEF at 0x20 -> mem_we N+1 with mem_addr 8, resp_valid N+2; a following load returns 0xDEADBEEF.
REQ-039 Word load at 0x22 and size-3 load at 0x10 -> resp_valid N+1, resp_misaligned 1, resp_rdata 0, no memory strobes.
REQ-040 rst pulsed in RD_WAIT of a byte store -> mem_we never asserted, no resp_valid, memory word unchanged, req_ready 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared core encodings: access sizes, LSU FSM states, alignment helper
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    RESP     = 3'd4
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = off[0];
      SIZE_W:  is_misaligned = (off != 2'd0);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  sh;
  logic [31:0] word_sh;
  logic [31:0] mask;

  assign sh      = {off_i, 3'b000};
  assign word_sh = word_i >> sh;

  always_comb begin
    load_o = word_i;
    mask   = 32'hFFFF_FFFF;
    case (size_i)
      SIZE_B: begin
        load_o = uns_i ? {24'd0, word_sh[7:0]} : {{24{word_sh[7]}}, word_sh[7:0]};
        mask   = 32'h0000_00FF << sh;
      end
      SIZE_H: begin
        load_o = uns_i ? {16'd0, word_sh[15:0]} : {{16{word_sh[15]}}, word_sh[15:0]};
        mask   = 32'h0000_FFFF << sh;
      end
      default: begin
        load_o = word_i;
        mask   = 32'hFFFF_FFFF;
      end
    endcase
    // Only the addressed lane(s) take store data; the rest keep the memory word
    merge_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit for a 32-bit core on a word-addressed memory
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] din_q, din_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic [31:0] load_data;
  logic [31:0] merged;

  lsu_lane u_lane (
    .word_i  (mem_dout),
    .wdata_i (wdata_q),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .load_o  (load_data),
    .merge_o (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[31:2];
          off_d   = req_addr[1:0];
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = '0;
          mis_d   = 1'b0;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            mis_d   = 1'b1;
            state_d = RESP;
          end else if (req_we && req_size == SIZE_W) begin
            din_d   = req_wdata;
            state_d = WR;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        // Sub-word stores pass through here to read-modify-write the word
        if (we_q) begin
          din_d   = merged;
          state_d = WR;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WR:       state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign req_ready       = (state_q == IDLE) && !rst;
  assign mem_re          = (state_q == RD_ISSUE);
  assign mem_we          = (state_q == WR);
  assign resp_valid      = (state_q == RESP);
  assign resp_misaligned = mis_q && resp_valid;
  assign resp_rdata      = rdata_q;
  assign mem_addr        = addr_q;
  assign mem_din         = din_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed scoreboard bench for lsu against a registered word memory model
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [29:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_dout = '0;

  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_addr        (mem_addr),
    .mem_din         (mem_din),
    .mem_re          (mem_re),
    .mem_we          (mem_we),
    .mem_dout        (mem_dout)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:0]] <= mem_din;
    if (mem_re) mem_dout <= mem[mem_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input int e_re, input int e_we, input int e_resp,
                         input logic [31:0] e_rdata, input logic e_mis, input logic [31:0] e_din);
    int   re_cyc;
    int   we_cyc;
    int   resp_cyc;
    exp_t e;
    exp_t got;
    re_cyc   = 0;
    we_cyc   = 0;
    resp_cyc = 0;
    e.rdata  = e_rdata;
    e.mis    = e_mis;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    sb.push_back(e);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_re) begin
        re_cyc = k;
        chk({tag, "_re_addr"}, {2'b00, mem_addr}, {2'b00, addr[31:2]});
      end
      if (mem_we) begin
        we_cyc = k;
        chk({tag, "_we_addr"}, {2'b00, mem_addr}, {2'b00, addr[31:2]});
        chk({tag, "_din"}, mem_din, e_din);
      end
      if (mem_re && mem_we) chk({tag, "_re_we_excl"}, 32'd1, 32'd0);
      if (resp_valid) begin
        resp_cyc = k;
        got = sb.pop_front();
        chk({tag, "_rdata"}, resp_rdata, got.rdata);
        chk({tag, "_mis"}, {31'd0, resp_misaligned}, {31'd0, got.mis});
        req_valid = 1'b0;
        break;
      end
      // Busy-time requests with different fields must be ignored
      req_valid    = 1'b1;
      req_we       = ~we;
      req_addr     = $urandom;
      req_wdata    = $urandom;
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = ~uns;
    end
    req_valid = 1'b0;
    if (resp_cyc == 0) begin
      void'(sb.pop_front());
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_re_cycle"}, re_cyc, e_re);
      chk({tag, "_we_cycle"}, we_cyc, e_we);
      chk({tag, "_resp_cycle"}, resp_cyc, e_resp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8081_7F02;

    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'd0, req_ready}, 32'd1);

    run_req("lb_13",  1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 1, 0, 3, 32'hFFFF_FF80, 1'b0, 32'h0);
    run_req("lhu_12", 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 1, 0, 3, 32'h0000_8081, 1'b0, 32'h0);
    run_req("lh_12",  1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 1, 0, 3, 32'hFFFF_8081, 1'b0, 32'h0);
    run_req("lbu_11", 1'b0, 32'h11, 32'h0, 2'd0, 1'b1, 1, 0, 3, 32'h0000_007F, 1'b0, 32'h0);
    run_req("lhu_10", 1'b0, 32'h10, 32'h0, 2'd1, 1'b1, 1, 0, 3, 32'h0000_7F02, 1'b0, 32'h0);
    run_req("sb_11",  1'b1, 32'h11, 32'hFFFF_FFAB, 2'd0, 1'b0, 1, 3, 4, 32'h0, 1'b0, 32'h8081_AB02);
    run_req("lw_10",  1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1, 0, 3, 32'h8081_AB02, 1'b0, 32'h0);
    run_req("sw_20",  1'b1, 32'h20, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, 1, 2, 32'h0, 1'b0, 32'hDEAD_BEEF);
    run_req("lw_20",  1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1, 0, 3, 32'hDEAD_BEEF, 1'b0, 32'h0);
    run_req("sh_22",  1'b1, 32'h22, 32'hCAFE_1234, 2'd1, 1'b0, 1, 3, 4, 32'h0, 1'b0, 32'h1234_BEEF);
    run_req("lw_20b", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1, 0, 3, 32'h1234_BEEF, 1'b0, 32'h0);
    run_req("lw_22_mis", 1'b0, 32'h22, 32'h0, 2'd2, 1'b0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
    run_req("l3_10_mis", 1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
    run_req("sh_11_mis", 1'b1, 32'h11, 32'h1111, 2'd1, 1'b0, 0, 0, 1, 32'h0, 1'b1, 32'h0);

    // Reset in RD_WAIT of a byte store must abandon it without writing
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h55;
    req_size  = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_re", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", {31'd0, req_ready}, 32'd0);
    chk("abort_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("abort_mem_din", mem_din, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_we_in_rst", {31'd0, mem_we}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("abort_ready_rel", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("abort_no_we", {31'd0, mem_we}, 32'd0);
    end
    chk("abort_mem_word", mem[4], 32'h8081_AB02);
    run_req("lw_10_after", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1, 0, 3, 32'h8081_AB02, 1'b0, 32'h0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
